// File: rtl/riscv_pkg.sv
// Shared definitions for the integer divide unit.
//   div_op_t    : operation encoding driven on div_op (DIV, DIVU, REM, REMU)
//   div_state_t : divider FSM states
//   DIV_ITERS   : number of restoring iterations (one quotient bit each)
//   cond_neg    : two's-complement negate when a flag is set
package riscv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    // Negate v when neg is set; used both to take operand magnitudes and to
    // restore the sign of the result.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   prem      in  33  partial remainder, already shifted left with the next
//                     dividend bit brought in
//   divisor   in  32  divisor magnitude
//   prem_next out 33  partial remainder after the trial subtraction
//   qbit      out  1  quotient bit produced by this iteration
module div_step (
    input  logic [32:0] prem,
    input  logic [31:0] divisor,
    output logic [32:0] prem_next,
    output logic        qbit
);

    // One extra bit so the borrow of the trial subtraction is visible.
    logic [33:0] diff;

    always_comb begin
        diff      = {1'b0, prem} - {2'b00, divisor};
        qbit      = ~diff[33];
        prem_next = qbit ? diff[32:0] : prem;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV / DIVU / REM / REMU).
// A restoring divider produces one quotient bit per cycle, MSB first.
// Operands are captured as magnitudes, and the sign is restored in the FIX
// state, which also applies the divide-by-zero and signed-overflow results.
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous active-high reset (beats flush and start)
//   start  in   1  launch an operation; only honoured in IDLE
//   a      in  32  dividend
//   b      in  32  divisor
//   div_op in   2  operation (see riscv_pkg::div_op_t)
//   flush  in   1  abort any operation in progress
//   busy   out  1  operation in flight, through the done cycle inclusive
//   done   out  1  one-cycle pulse, result valid
//   result out 32  quotient or remainder, held until the next done
// Build option: define DIV_EARLY_OUT_EN to skip the iterations for
// divide-by-zero and signed overflow (done 2 cycles after start instead of 34).
module div_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  div_op,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [32:0]        prem_reg;    // partial remainder
    logic [31:0]        quot_reg;    // dividend magnitude shifts out, quotient shifts in
    logic [31:0]        dvsr_reg;    // divisor magnitude
    logic [31:0]        a_reg;       // raw dividend, returned as remainder on divide by zero
    div_op_t            op_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               zero_reg;
    logic               ovf_reg;
    logic [31:0]        fix_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [31:0]        result_reg;

    // Input-side decode, used only when an operation is accepted.
    logic               signed_in;
    logic               zero_in;
    logic               ovf_in;

    assign signed_in = (div_op == DIV) || (div_op == REM);
    assign zero_in   = (b == 32'd0);
    assign ovf_in    = signed_in && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Restoring iteration: bring the next dividend bit into the remainder.
    // The remainder is always below the divisor, so bit 32 is zero before
    // the shift and nothing is lost.
    logic [32:0]        step_in;
    logic [32:0]        step_out;
    logic               step_qbit;
    logic               unused_prem_msb;

    assign step_in         = {prem_reg[31:0], quot_reg[31]};
    assign unused_prem_msb = prem_reg[32];

    div_step u_step (
        .prem      (step_in),
        .divisor   (dvsr_reg),
        .prem_next (step_out),
        .qbit      (step_qbit)
    );

    // Sign correction and special-case override, registered in FIX.
    logic [31:0]        fix_val;

    always_comb begin
        fix_val = 32'd0;
        if ((op_reg == REM) || (op_reg == REMU)) begin
            if (zero_reg)
                fix_val = a_reg;
            else if (ovf_reg)
                fix_val = 32'd0;
            else
                fix_val = cond_neg(prem_reg[31:0], neg_r_reg);
        end else begin
            if (zero_reg)
                fix_val = 32'hFFFF_FFFF;
            else if (ovf_reg)
                fix_val = 32'h8000_0000;
            else
                fix_val = cond_neg(quot_reg, neg_q_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            prem_reg   <= '0;
            quot_reg   <= '0;
            dvsr_reg   <= '0;
            a_reg      <= '0;
            op_reg     <= DIV;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            fix_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (flush) begin
            // Abandon the operation; result keeps its last value.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    // done_reg high means this is the done cycle of the
                    // previous operation: start is ignored until it drops.
                    if (start && !done_reg) begin
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        prem_reg  <= '0;
                        quot_reg  <= cond_neg(a, signed_in && a[31]);
                        dvsr_reg  <= cond_neg(b, signed_in && b[31]);
                        a_reg     <= a;
                        op_reg    <= div_op_t'(div_op);
                        neg_q_reg <= signed_in && (a[31] ^ b[31]);
                        neg_r_reg <= signed_in && a[31];
                        zero_reg  <= zero_in;
                        ovf_reg   <= ovf_in;
`ifdef DIV_EARLY_OUT_EN
                        state_reg <= (zero_in || ovf_in) ? FIX : CALC;
`else
                        state_reg <= CALC;
`endif
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                CALC: begin
                    prem_reg <= step_out;
                    quot_reg <= {quot_reg[30:0], step_qbit};
                    if (cnt_reg == CNT_W'(DIV_ITERS - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FIX: begin
                    fix_reg   <= fix_val;
                    state_reg <= DONE;
                end
                DONE: begin
                    // busy_reg stays high through the done cycle and is
                    // cleared from IDLE on the following edge.
                    result_reg <= fix_reg;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed operations with expected
// results queued at launch and compared when done pulses.
module tb_div_unit;
    import riscv_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 34;
`endif
    localparam int LAT_NORMAL = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  div_op;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .div_op (div_op),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] op);
        logic is_rem;
        is_rem = op[1];
        if (y == 32'd0)
            return is_rem ? x : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return is_rem ? 32'd0 : 32'h8000_0000;
            return is_rem ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
        end
        return is_rem ? (x % y) : (x / y);
    endfunction

    function automatic int lat_of(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
        if (y == 32'd0) return LAT_SPECIAL;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    // Count done pulses over n cycles (no launch expected).
    task automatic watch_quiet(input string tag, input int n);
        int pulses = 0;
        int busy_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        check({tag, "_no_done"}, 32'(pulses), 32'd0);
        check({tag, "_no_busy"}, 32'(busy_seen), 32'd0);
    endtask

    // Launch one operation and follow it to done.
    //   inject_at     : cycle after start at which a stray start is driven (-1: none)
    //   start_on_done : drive start during the done cycle (must be ignored)
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [1:0] op, input logic [31:0] expv, input int exp_lat,
                         input int inject_at, input bit start_on_done);
        int          lat;
        bit          busy_ok;
        logic [31:0] e;
        exp_q.push_back(expv);
        a = ta; b = tb_v; div_op = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = busy;
        while (!done && lat < 100) begin
            if (lat == inject_at) begin
                start = 1'b1; a = 32'h0000_1234; b = 32'd1; div_op = DIVU;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        e = exp_q.pop_front();
        check({tag, "_result"}, result, e);
        last_res = e;
        $display("op %s a=%h b=%h op=%0d -> result=%h latency=%0d", tag, ta, tb_v, op, result, lat);
        if (start_on_done) begin
            start = 1'b1; a = 32'd77; b = 32'd7; div_op = DIVU;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_after_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        a = 32'd0; b = 32'd0; div_op = DIV;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'd0);
        check("reset_flags", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("divu_100_7", 32'd100, 32'd7, DIVU, 32'd14, LAT_NORMAL, -1, 1'b0);
        do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, DIV, 32'hFFFF_FFFD, LAT_NORMAL, -1, 1'b0);
        do_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, REM, 32'hFFFF_FFFF, LAT_NORMAL, -1, 1'b0);
        do_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, REM, 32'd1, LAT_NORMAL, -1, 1'b0);
        do_op("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV, 32'd14, LAT_NORMAL, -1, 1'b0);
        do_op("divu_5_0", 32'd5, 32'd0, DIVU, 32'hFFFF_FFFF, LAT_SPECIAL, -1, 1'b0);
        do_op("remu_5_0", 32'd5, 32'd0, REMU, 32'd5, LAT_SPECIAL, -1, 1'b0);
        do_op("div_5_0", 32'd5, 32'd0, DIV, 32'hFFFF_FFFF, LAT_SPECIAL, -1, 1'b0);
        do_op("rem_m5_0", 32'hFFFF_FFFB, 32'd0, REM, 32'hFFFF_FFFB, LAT_SPECIAL, -1, 1'b0);
        do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, DIV, 32'h8000_0000, LAT_SPECIAL, -1, 1'b0);
        do_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, REM, 32'd0, LAT_SPECIAL, -1, 1'b0);
        do_op("divu_max", 32'hFFFF_FFFF, 32'd1, DIVU, 32'hFFFF_FFFF, LAT_NORMAL, -1, 1'b0);
        // Stray start while busy must not disturb the operation.
        do_op("busy_start", 32'd1000, 32'd33, DIVU, 32'd30, LAT_NORMAL, 5, 1'b0);

        // Flush 10 cycles after start.
        a = 32'd1000; b = 32'd10; div_op = DIVU; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush applied: busy=%b done=%b result=%h", busy, done, result);
        check("flush_flags", {30'd0, busy, done}, 32'd0);
        watch_quiet("flush", 40);
        check("flush_result_kept", result, last_res);
        do_op("divu_9_3", 32'd9, 32'd3, DIVU, 32'd3, LAT_NORMAL, -1, 1'b0);

        // Start and flush together: flush wins.
        a = 32'd50; b = 32'd5; div_op = DIVU; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        $display("start+flush: busy=%b done=%b", busy, done);
        watch_quiet("start_flush", 40);

        // Reset 5 cycles into a DIV.
        a = 32'd100; b = 32'd3; div_op = DIV; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid-op reset: busy=%b done=%b result=%h", busy, done, result);
        check("midreset_flags", {30'd0, busy, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        last_res = 32'd0;
        watch_quiet("midreset", 40);

        // Start during the done cycle is ignored.
        do_op("divu_50_5", 32'd50, 32'd5, DIVU, 32'd10, LAT_NORMAL, -1, 1'b1);
        watch_quiet("done_start", 40);
        check("done_start_result", result, last_res);

        // A few random vectors against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : ($urandom >> (i * 5));
            rop = 2'($urandom_range(0, 3));
            do_op("random", ra, rb, rop, ref_div(ra, rb, rop), lat_of(ra, rb, rop), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
